// File: rtl/gate_model_bist.sv
// gate_model_bist: LFSR pattern source and MISR response compactor for BIST of combinational gate models.
// Optional feature macro GATE_BIST_COMPARE_EN builds the golden-signature comparator behind pass.
module gate_model_bist #(
  parameter int PAT_W  = 15,
  parameter int RESP_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [PAT_W-1:0]  seed,
  output logic [PAT_W-1:0]  pat_out,
  input  logic [RESP_W-1:0] resp_in,
  input  logic [RESP_W-1:0] expected_sig,
  output logic              busy,
  output logic              done,
  output logic [RESP_W-1:0] signature,
  output logic              pass
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [PAT_W-1:0] lfsr_next;
  logic [RESP_W-1:0] misr_next;
  logic pass_run, pass_zero;
  // x^15+x^14+1 Fibonacci step and x^10+x^3+1 MISR absorb of the current response
  always_comb begin
    lfsr_next = {pat_out[PAT_W-2:0], pat_out[PAT_W-1] ^ pat_out[PAT_W-2]};
    misr_next = {signature[RESP_W-2:0], signature[RESP_W-1]}
              ^ ({{(RESP_W-1){1'b0}}, signature[RESP_W-1]} << 3) ^ resp_in;
  end
`ifdef GATE_BIST_COMPARE_EN
  assign pass_run  = misr_next == expected_sig;
  assign pass_zero = expected_sig == '0;
`else
  logic unused_expected;
  assign unused_expected = ^expected_sig;
  assign pass_run  = 1'b0;
  assign pass_zero = 1'b0;
`endif
  // run sequencer: abort wins over start and completion; zero-length runs go straight to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat_out   <= PAT_W'(1);
      signature <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      signature <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (state != RUN && start) begin
      signature <= '0;
      cnt       <= num_patterns;
      if (num_patterns != '0) begin
        state   <= RUN;
        pat_out <= seed == '0 ? PAT_W'(1) : seed;
        busy    <= 1'b1;
        done    <= 1'b0;
        pass    <= 1'b0;
      end else begin
        state   <= DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        pass    <= pass_zero;
      end
    end else if (state == RUN) begin
      pat_out   <= lfsr_next;
      signature <= misr_next;
      cnt       <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= pass_run;
      end
    end
  end
endmodule

// File: tb/tb_gate_model_bist.sv
// tb_gate_model_bist: directed checks of gate_model_bist sequencing, LFSR/MISR values and abort/reset behaviour.
module tb_gate_model_bist;
  logic clk, rst_n, start, abort, busy, done, pass;
  logic [15:0] num_patterns;
  logic [14:0] seed, pat_out;
  logic [9:0] resp_in, expected_sig, signature;
  int checks = 0, fails = 0;
`ifdef GATE_BIST_COMPARE_EN
  localparam logic CMP = 1'b1;
`else
  localparam logic CMP = 1'b0;
`endif
  gate_model_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_patterns(num_patterns), .seed(seed), .pat_out(pat_out),
    .resp_in(resp_in), .expected_sig(expected_sig), .busy(busy),
    .done(done), .signature(signature), .pass(pass)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic kick(input logic [14:0] s, input logic [15:0] n);
    seed = s;
    num_patterns = n;
    start = 1;
    tick();
    start = 0;
  endtask
  logic [14:0] seq [16];
  initial begin
    for (int k = 0; k < 14; k++) seq[k] = 15'(1) << k;
    seq[14] = 15'h4001;
    seq[15] = 15'h0003;
    rst_n = 0; start = 0; abort = 0; num_patterns = 0; seed = 0;
    resp_in = 0; expected_sig = 0;
    #12;
    check("rst_pat", pat_out, 15'h0001);
    check("rst_sig", signature, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    rst_n = 1;
    tick();
    kick(15'h0001, 16);
    check("s16_busy", busy, 1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("s16_pat%0d", k), pat_out, seq[k]);
      check($sformatf("s16_nodone%0d", k), done, 0);
      tick();
    end
    check("s16_done", done, 1);
    check("s16_busy_low", busy, 0);
    check("s16_sig", signature, 0);
    check("s16_pass", pass, CMP);
    resp_in = 10'h001;
    expected_sig = 10'h003;
    kick(15'h0000, 2);
    check("n2_pat0", pat_out, 15'h0001);
    check("n2_busy1", busy, 1);
    check("n2_sig0", signature, 0);
    check("n2_pass_clr", pass, 0);
    tick();
    check("n2_pat1", pat_out, 15'h0002);
    check("n2_busy2", busy, 1);
    check("n2_sig1", signature, 10'h001);
    tick();
    check("n2_done", done, 1);
    check("n2_busy_low", busy, 0);
    check("n2_sig", signature, 10'h003);
    check("n2_pass_good", pass, CMP);
    expected_sig = 10'h002;
    kick(15'h0000, 2);
    tick();
    tick();
    check("n2b_sig", signature, 10'h003);
    check("n2b_pass_bad", pass, 0);
    abort = 1;
    tick();
    abort = 0;
    check("abt_done", done, 0);
    check("abt_sig", signature, 0);
    expected_sig = 0;
    kick(15'h0007, 0);
    check("n0_done", done, 1);
    check("n0_busy", busy, 0);
    check("n0_sig", signature, 0);
    check("n0_pass", pass, CMP);
    kick(15'h0001, 4);
    seed = 15'h1234;
    num_patterns = 9;
    start = 1;
    tick();
    start = 0;
    check("nrs_pat", pat_out, 15'h0002);
    check("nrs_busy", busy, 1);
    tick();
    tick();
    check("ab4_pat", pat_out, 15'h0008);
    abort = 1;
    tick();
    abort = 0;
    check("ab4_done", done, 0);
    check("ab4_busy", busy, 0);
    check("ab4_sig", signature, 0);
    check("ab4_pat_hold", pat_out, 15'h0008);
    tick();
    check("ab4_idle", done | busy, 0);
    kick(15'h0005, 10);
    tick();
    tick();
    tick();
    check("mr_sig", signature, 10'h007);
    check("mr_pat", pat_out, 15'h0028);
    rst_n = 0;
    #1;
    check("mr_pat_rst", pat_out, 15'h0001);
    check("mr_sig_rst", signature, 0);
    check("mr_busy_rst", busy, 0);
    check("mr_done_rst", done, 0);
    #2;
    rst_n = 1;
    expected_sig = 10'h003;
    kick(15'h0000, 2);
    check("mr2_busy", busy, 1);
    tick();
    tick();
    check("mr2_done", done, 1);
    check("mr2_sig", signature, 10'h003);
    check("mr2_pass", pass, CMP);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
